// File: rtl/id_stage_pipe.sv
// Registered ID stage: operand forwarding from EX/MEM, branch/JR resolution,
// load-use stall control and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_WIDTH  = 4,
  parameter int CTRL_WIDTH = 8,
  parameter int LOAD_STALL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid_i,
  input  logic [CTRL_WIDTH-1:0]  ctrl_i,
  input  logic [REG_WIDTH-1:0]   rs1_i,
  input  logic [REG_WIDTH-1:0]   rs2_i,
  input  logic                   rs1_used_i,
  input  logic                   rs2_used_i,
  input  logic [DATA_WIDTH-1:0]  rdata1_i,
  input  logic [DATA_WIDTH-1:0]  rdata2_i,
  input  logic [DATA_WIDTH-1:0]  imm_i,
  input  logic [DATA_WIDTH-1:0]  pcplus1_i,
  input  logic                   is_branch_i,
  input  logic [1:0]             br_mode_i,
  input  logic                   ex_regwrite_i,
  input  logic                   ex_memread_i,
  input  logic [REG_WIDTH-1:0]   ex_regdst_i,
  input  logic [DATA_WIDTH-1:0]  ex_data_i,
  input  logic                   mem_regwrite_i,
  input  logic [REG_WIDTH-1:0]   mem_regdst_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic                   ex_stall_i,
  output logic                   stall_o,
  output logic                   ifbranch_o,
  output logic [DATA_WIDTH-1:0]  target_o,
  output logic                   idex_valid_o,
  output logic [CTRL_WIDTH-1:0]  idex_ctrl_o,
  output logic [DATA_WIDTH-1:0]  idex_a_o,
  output logic [DATA_WIDTH-1:0]  idex_b_o,
  output logic [DATA_WIDTH-1:0]  idex_imm_o,
  output logic [2*REG_WIDTH-1:0] idex_rd_src_o
);

  typedef enum logic {RUN, STALL} state_t;

  // The hazard cycle in RUN is itself the first bubble, so STALL only
  // covers the remaining LOAD_STALL-1 cycles.
  localparam bit         MULTI    = (LOAD_STALL > 1);
  localparam logic [2:0] CNT_INIT = MULTI ? 3'(LOAD_STALL - 2) : 3'd0;

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;
  logic                  rs1_eff, hazard, cond;

  always_comb begin
    fwd_a = rdata1_i;
    if (ex_regwrite_i && !ex_memread_i && ex_regdst_i == rs1_i) fwd_a = ex_data_i;
    else if (mem_regwrite_i && mem_regdst_i == rs1_i)            fwd_a = mem_data_i;
    fwd_b = rdata2_i;
    if (ex_regwrite_i && !ex_memread_i && ex_regdst_i == rs2_i) fwd_b = ex_data_i;
    else if (mem_regwrite_i && mem_regdst_i == rs2_i)            fwd_b = mem_data_i;
  end

  // Conditional branches and JR read rs1 even if the decoder did not flag it.
  assign rs1_eff = rs1_used_i | (is_branch_i & (br_mode_i != 2'b00));
  assign hazard  = id_valid_i & ex_regwrite_i & ex_memread_i &
                   ((rs1_eff & (ex_regdst_i == rs1_i)) |
                    (rs2_used_i & (ex_regdst_i == rs2_i)));

  assign stall_o = ((state == RUN) & hazard) | (state == STALL) | ex_stall_i;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: if (hazard && MULTI) begin
        state_nxt = STALL;
        cnt_nxt   = CNT_INIT;
      end
      STALL: if (!id_valid_i || cnt == 3'd0) begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end else begin
        cnt_nxt = cnt - 3'd1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    cond = 1'b1;
    case (br_mode_i)
      2'b01:   cond = (fwd_a == '0);
      2'b10:   cond = (fwd_a != '0);
      default: cond = 1'b1;
    endcase
  end

  assign ifbranch_o = id_valid_i & is_branch_i & ~stall_o & cond;
  assign target_o   = (br_mode_i == 2'b11) ? fwd_a : pcplus1_i + imm_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_valid_o  <= 1'b0;
      idex_ctrl_o   <= '0;
      idex_a_o      <= '0;
      idex_b_o      <= '0;
      idex_imm_o    <= '0;
      idex_rd_src_o <= '0;
    end else if (!ex_stall_i) begin
      if (stall_o || !id_valid_i) begin
        idex_valid_o  <= 1'b0;
        idex_ctrl_o   <= '0;
        idex_a_o      <= '0;
        idex_b_o      <= '0;
        idex_imm_o    <= '0;
        idex_rd_src_o <= '0;
      end else begin
        idex_valid_o  <= 1'b1;
        idex_ctrl_o   <= ctrl_i;
        idex_a_o      <= fwd_a;
        idex_b_o      <= fwd_b;
        idex_imm_o    <= imm_i;
        idex_rd_src_o <= {rs1_i, rs2_i};
      end
    end
  end

endmodule
